// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the error-flag record for the parametrised FIFO.
package fifo_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

endpackage

// File: rtl/fifo_param_if.sv
// Port bundle between the producer/consumer side (master) and fifo_param (slave).
// Handshake: on a rising edge a write is taken when in_write_ctrl is high and the FIFO is not
// full or a read is taken on the same edge; a read is taken when in_read_ctrl is high and the
// FIFO is not empty. There is no ready/stall: rejected requests set the sticky error flags.
interface fifo_param_if import fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) ();
   logic                      in_write_ctrl;
   logic [WIDTH-1:0]          in_write_data;
   logic                      in_read_ctrl;
   logic                      in_clear_err;
   logic [WIDTH-1:0]          out_read_data;
   logic                      out_read_valid;
   logic [cnt_w(DEPTH)-1:0]   out_count;
   logic                      out_is_full;
   logic                      out_is_empty;
   logic                      out_almost_full;
   logic                      out_almost_empty;
   logic                      out_overflow;
   logic                      out_underflow;

   modport master (
      output in_write_ctrl, in_write_data, in_read_ctrl, in_clear_err,
      input  out_read_data, out_read_valid, out_count, out_is_full, out_is_empty,
             out_almost_full, out_almost_empty, out_overflow, out_underflow
   );

   modport slave (
      input  in_write_ctrl, in_write_data, in_read_ctrl, in_clear_err,
      output out_read_data, out_read_valid, out_count, out_is_full, out_is_empty,
             out_almost_full, out_almost_empty, out_overflow, out_underflow
   );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem import fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
   output logic [WIDTH-1:0]          rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count and sticky error flags.
// Define FIFO_PARAM_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module fifo_param import fifo_pkg::*; #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic         clk,
   input  logic         rst,
   fifo_param_if.slave  bus
);
   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [PW-1:0]    wptr, rptr;
   logic [CW-1:0]    count;
   err_flags_t       err;
   logic             full, empty, wr_acc, rd_acc;
   logic [WIDTH-1:0] head;

   assign full   = (count == CNT_MAX);
   assign empty  = (count == '0);
   assign rd_acc = bus.in_read_ctrl & ~empty;
   // A pop on the same edge frees a slot, so a full FIFO still takes the write.
   assign wr_acc = bus.in_write_ctrl & (~full | rd_acc);

   fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wptr),
      .wr_data (bus.in_write_data),
      .rd_addr (rptr),
      .rd_data (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= '0;
      end else begin
         if (wr_acc) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
         if (rd_acc) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
         if (wr_acc & ~rd_acc)      count <= count + 1'b1;
         else if (rd_acc & ~wr_acc) count <= count - 1'b1;
         // Setting beats clearing when both happen on the same edge.
         if (bus.in_write_ctrl & ~wr_acc) err.overflow <= 1'b1;
         else if (bus.in_clear_err)       err.overflow <= 1'b0;
         if (bus.in_read_ctrl & empty)    err.underflow <= 1'b1;
         else if (bus.in_clear_err)       err.underflow <= 1'b0;
      end
   end

   assign bus.out_count        = count;
   assign bus.out_is_full      = full;
   assign bus.out_is_empty     = empty;
   assign bus.out_almost_full  = (int'(count) >= AFULL_TH);
   assign bus.out_almost_empty = (int'(count) <= AEMPTY_TH);
   assign bus.out_overflow     = err.overflow;
   assign bus.out_underflow    = err.underflow;

`ifdef FIFO_PARAM_FWFT_EN
   assign bus.out_read_data  = head;
   assign bus.out_read_valid = ~empty;
`else
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= head;
      end
   end

   assign bus.out_read_data  = rd_data_q;
   assign bus.out_read_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: DEPTH=8 and DEPTH=5 instances share one stimulus stream and are each
// compared every cycle against a queue-based model; directed sequences pin literal values.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int W = 8;
`ifdef FIFO_PARAM_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [W-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rdata [2];
  logic         rvalid [2], full [2], empty [2], afull [2], aempty [2], ovf [2], unf [2];
  logic [3:0]   cnt [2];

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int D = (g == 0) ? 8 : 5;
    fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();
    fifo_param #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.in_write_ctrl = wr;
    assign bus.in_write_data = wdata;
    assign bus.in_read_ctrl  = rd;
    assign bus.in_clear_err  = clr;
    assign rdata[g]  = bus.out_read_data;
    assign rvalid[g] = bus.out_read_valid;
    assign cnt[g]    = 4'(bus.out_count);
    assign full[g]   = bus.out_is_full;
    assign empty[g]  = bus.out_is_empty;
    assign afull[g]  = bus.out_almost_full;
    assign aempty[g] = bus.out_almost_empty;
    assign ovf[g]    = bus.out_overflow;
    assign unf[g]    = bus.out_underflow;
  end

  // behavioural model: one queue per instance plus the visible read/error state
  logic [W-1:0] exp_q [2][$];
  logic [W-1:0] m_data [2];
  logic         m_valid [2], m_ovf [2], m_unf [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
      m_ovf[i]   = 1'b0;
      m_unf[i]   = 1'b0;
    end
  endtask

  // Applies one clock edge to the model using the request inputs held across that edge.
  task automatic model_step();
    int  n;
    bit  was_full, was_empty, rda, wra;
    for (int i = 0; i < 2; i++) begin
      n         = exp_q[i].size();
      was_full  = (n == depth_of(i));
      was_empty = (n == 0);
      rda       = rd && !was_empty;
      wra       = wr && (!was_full || rda);
      m_valid[i] = rda;
      if (rda) m_data[i] = exp_q[i].pop_front();
      if (wra) exp_q[i].push_back(wdata);
      if (wr && !wra) m_ovf[i] = 1'b1;
      else if (clr)   m_ovf[i] = 1'b0;
      if (rd && was_empty) m_unf[i] = 1'b1;
      else if (clr)        m_unf[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [depth %0d] at %0t: got 0x%0h, expected 0x%0h", name, depth_of(i), $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    wr = w; wdata = d; rd = r; clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  // Pops one word (optionally writing at the same edge) and checks it is exp.
  task automatic pop_check(input int i, input logic w, input logic [W-1:0] d, input logic [W-1:0] exp);
`ifdef FIFO_PARAM_FWFT_EN
    chk("fwft_head_valid", i, rvalid[i], 1);
    chk("fwft_head_data", i, rdata[i], exp);
    cycle(w, d, 1'b1, 1'b0);
`else
    cycle(w, d, 1'b1, 1'b0);
    chk("pop_valid", i, rvalid[i], 1);
    chk("pop_data", i, rdata[i], exp);
`endif
  endtask

  // scoreboard compare, every cycle on the falling edge
  initial forever begin
    int n, d;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n = exp_q[i].size();
      d = depth_of(i);
      chk("count", i, cnt[i], n);
      chk("is_full", i, full[i], n == d);
      chk("is_empty", i, empty[i], n == 0);
      chk("almost_full", i, afull[i], n >= d - 2);
      chk("almost_empty", i, aempty[i], n <= 2);
      chk("overflow", i, ovf[i], m_ovf[i]);
      chk("underflow", i, unf[i], m_unf[i]);
      if (FWFT) begin
        chk("read_valid", i, rvalid[i], n != 0);
        if (n != 0) chk("read_data", i, rdata[i], exp_q[i][0]);
      end else begin
        chk("read_valid", i, rvalid[i], m_valid[i]);
        chk("read_data", i, rdata[i], m_data[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_count", i, cnt[i], 0);
      chk("rst_empty", i, empty[i], 1);
      chk("rst_aempty", i, aempty[i], 1);
      chk("rst_full", i, full[i], 0);
      chk("rst_afull", i, afull[i], 0);
      chk("rst_ovf", i, ovf[i], 0);
      chk("rst_unf", i, unf[i], 0);
      chk("rst_valid", i, rvalid[i], 0);
    end
    chk("rst_data", 0, rdata[0], 0);
    rst = 1'b0;

`ifdef FIFO_PARAM_FWFT_EN
    // first word falls through without a read request
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_valid_no_read", 0, rvalid[0], 1);
    chk("fwft_data_no_read", 0, rdata[0], 8'h3C);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_valid_after_pop", 0, rvalid[0], 0);
`else
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("reg_no_valid_without_read", 0, rvalid[0], 0);
    pop_check(0, 1'b0, '0, 8'h3C);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("reg_valid_one_cycle", 0, rvalid[0], 0);
`endif

    // fill 0x01..0x08, then drain in order
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 8'(k), 1'b0, 1'b0);
      chk("fill_count", 0, cnt[0], k);
      chk("fill_afull", 0, afull[0], k >= 6);
    end
    chk("fill_full", 0, full[0], 1);
    chk("d5_overflow_after_fill", 1, ovf[1], 1);
    chk("d5_count_capped", 1, cnt[1], 5);
    for (int k = 1; k <= 8; k++) pop_check(0, 1'b0, '0, 8'(k));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", 0, empty[0], 1);
    chk("drain_valid_low", 0, rvalid[0], 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 1, ovf[1], 0);
    chk("clr_unf", 1, unf[1], 0);

    // overflow drops the word; clear releases the flag
    for (int k = 0; k < 8; k++) cycle(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    chk("full_no_ovf_yet", 0, ovf[0], 0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 0, ovf[0], 1);
    chk("ovf_count", 0, cnt[0], 8);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 0, ovf[0], 0);
    for (int k = 0; k < 8; k++) pop_check(0, 1'b0, '0, 8'(8'h10 + k));
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("set_beats_clear", 0, unf[0], 1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // read+write while empty: write taken, read flagged
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("empty_rw_unf", 0, unf[0], 1);
    chk("empty_rw_count", 0, cnt[0], 1);
    chk("empty_rw_valid", 0, rvalid[0], FWFT);
    pop_check(0, 1'b0, '0, 8'h55);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // pointer wrap on DEPTH=5 with a steady count of 3
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      pop_check(1, 1'b1, 8'(8'h23 + k), 8'(8'h20 + k));
      chk("wrap_count", 1, cnt[1], 3);
    end
    cycle(1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    chk("d5_full", 1, full[1], 1);
    pop_check(1, 1'b1, 8'h42, 8'h2C);
    chk("full_rw_count", 1, cnt[1], 5);
    chk("full_rw_full", 1, full[1], 1);
    chk("full_rw_no_ovf", 1, ovf[1], 0);
    pop_check(1, 1'b0, '0, 8'h2D);
    pop_check(1, 1'b0, '0, 8'h2E);
    pop_check(1, 1'b0, '0, 8'h40);
    pop_check(1, 1'b0, '0, 8'h41);
    pop_check(1, 1'b0, '0, 8'h42);

    // asynchronous reset between edges
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
    chk("pre_rst_count", 0, cnt[0], 4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_empty", i, empty[i], 1);
      chk("async_rst_count", i, cnt[i], 0);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_unf", 0, unf[0], 1);
    chk("post_rst_valid", 0, rvalid[0], 0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 800; n++) begin
      int wp, rp;
      wp = ((n / 100) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      cycle($urandom_range(99, 0) < wp, 8'($urandom), $urandom_range(99, 0) < rp,
            $urandom_range(19, 0) == 0);
    end
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
